// File: rtl/psum_pkg.sv
// Shared types and arithmetic helpers for the partial-sum drain/accumulate stage.
package psum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FINAL = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // Wide working width for saturation; accumulators must stay narrower than this.
    localparam int SAT_W = 64;

    function automatic int acc_width(input int i_w, input int f_w, input int guard);
        return i_w + f_w + guard;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] v,
                                                    input int w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with registered storage; DEPTH must be a power of 2 (>= 2).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/psum_drain_accum.sv
// Accumulates array-edge partial sums over several channel passes and streams
// the saturated final pass out through a small FIFO.
module psum_drain_accum
    import psum_pkg::*;
#(
    parameter int I_WIDTH    = 8,
    parameter int F_WIDTH    = 8,
    parameter int GUARD      = 4,
    parameter int DEPTH      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_WIDTH  = $clog2(DEPTH + 1),
    parameter int PASS_WIDTH = 8,
    localparam int P_W       = I_WIDTH + F_WIDTH,
    localparam int ACC_W     = acc_width(I_WIDTH, F_WIDTH, GUARD)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [LEN_WIDTH-1:0]  pass_len_i,
    input  logic [PASS_WIDTH-1:0] num_pass_i,
    input  logic [P_W-1:0]        psum_i,
    input  logic                  psum_valid_i,
    output logic                  psum_ready_o,
    output logic [ACC_W-1:0]      out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overflow_o
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    idx_q, idx_d, len_q, len_d;
    logic [PASS_WIDTH-1:0]   pass_cnt_q, pass_cnt_d, npass_q, npass_d;
    logic                    done_q, done_d, ovf_q, ovf_d;

    logic signed [ACC_W-1:0] acc_buf [DEPTH];
    logic signed [ACC_W-1:0] psum_ext, buf_rd, acc_sat, buf_wdata, push_data;
    logic signed [SAT_W-1:0] sum_wide, sum_sat;
    logic                    beat, last_idx, sat_hit, buf_we;
    logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ACC_W-1:0]        fifo_dout;

    // Ready depends only on registered state, so a pop never feeds straight into ready.
    assign psum_ready_o = (state_q == ACCUM) || ((state_q == FINAL) && !fifo_full);
    assign out_valid_o  = !fifo_empty;
    assign out_data_o   = fifo_empty ? '0 : fifo_dout;
    assign fifo_pop     = out_valid_o && out_ready_i;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;
    assign overflow_o   = ovf_q;

    always_comb begin
        psum_ext   = ACC_W'($signed(psum_i));
        buf_rd     = acc_buf[idx_q[IDX_W-1:0]];
        sum_wide   = SAT_W'(buf_rd) + SAT_W'(psum_ext);
        sum_sat    = sat(sum_wide, ACC_W);
        acc_sat    = ACC_W'(sum_sat);
        sat_hit    = (sum_sat != sum_wide);
        beat       = psum_valid_i && psum_ready_o;
        last_idx   = (idx_q == len_q - LEN_WIDTH'(1));

        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        pass_cnt_d = pass_cnt_q;
        npass_d    = npass_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        buf_we     = 1'b0;
        buf_wdata  = acc_sat;
        fifo_push  = 1'b0;
        push_data  = acc_sat;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d      = pass_len_i;
                    npass_d    = num_pass_i;
                    idx_d      = '0;
                    pass_cnt_d = '0;
                    ovf_d      = 1'b0;
                    if ((pass_len_i == '0) || (num_pass_i == '0)) begin
                        done_d = 1'b1;
                    end else if (num_pass_i == PASS_WIDTH'(1)) begin
                        state_d = FINAL;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (beat) begin
                    buf_we = 1'b1;
                    if (pass_cnt_q == '0) begin
                        buf_wdata = psum_ext;
                    end else begin
                        ovf_d = ovf_q | sat_hit;
                    end
                    if (last_idx) begin
                        idx_d      = '0;
                        pass_cnt_d = pass_cnt_q + PASS_WIDTH'(1);
                        if (pass_cnt_q == npass_q - PASS_WIDTH'(2)) begin
                            state_d = FINAL;
                        end
                    end else begin
                        idx_d = idx_q + LEN_WIDTH'(1);
                    end
                end
            end
            FINAL: begin
                if (beat) begin
                    fifo_push = 1'b1;
                    if (npass_q == PASS_WIDTH'(1)) begin
                        push_data = psum_ext;
                    end else begin
                        ovf_d = ovf_q | sat_hit;
                    end
                    if (last_idx) begin
                        idx_d      = '0;
                        pass_cnt_d = pass_cnt_q + PASS_WIDTH'(1);
                        state_d    = FLUSH;
                    end else begin
                        idx_d = idx_q + LEN_WIDTH'(1);
                    end
                end
            end
            FLUSH: begin
                if (fifo_empty) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            pass_cnt_q <= '0;
            npass_q    <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            pass_cnt_q <= pass_cnt_d;
            npass_q    <= npass_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    // Pass 0 always overwrites, so the buffer needs no reset.
    always_ff @(posedge clk_i) begin
        if (buf_we) begin
            acc_buf[idx_q[IDX_W-1:0]] <= buf_wdata;
        end
    end

    sync_fifo #(
        .WIDTH (ACC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (fifo_push),
        .push_data_i (push_data),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_dout),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

endmodule

// File: tb/tb_psum_drain_accum.sv
// Scoreboard bench for psum_drain_accum: default instance plus a GUARD=0 instance for saturation.
module tb_psum_drain_accum;
    localparam int ACC_W = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        start, pvalid, pready, ovalid, oready, busy, done, ovf;
    logic [4:0]  plen;
    logic [7:0]  npass;
    logic [15:0] psum;
    logic [19:0] odata;

    logic        g_start, g_pvalid, g_pready, g_ovalid, g_busy, g_done, g_ovf;
    logic [4:0]  g_plen;
    logic [7:0]  g_npass;
    logic [15:0] g_psum, g_odata;

    int     n_cmp = 0;
    int     n_err = 0;
    int     done_cnt = 0;
    longint exp_q[$];
    longint stim[$];

    psum_drain_accum dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .pass_len_i(plen), .num_pass_i(npass),
        .psum_i(psum), .psum_valid_i(pvalid), .psum_ready_o(pready),
        .out_data_o(odata), .out_valid_o(ovalid), .out_ready_i(oready),
        .busy_o(busy), .done_o(done), .overflow_o(ovf)
    );

    psum_drain_accum #(.GUARD(0)) dut_g0 (
        .clk_i(clk), .rst_i(rst), .start_i(g_start), .pass_len_i(g_plen), .num_pass_i(g_npass),
        .psum_i(g_psum), .psum_valid_i(g_pvalid), .psum_ready_o(g_pready),
        .out_data_o(g_odata), .out_valid_o(g_ovalid), .out_ready_i(1'b1),
        .busy_o(g_busy), .done_o(g_done), .overflow_o(g_ovf)
    );

    task automatic check_eq(input string tag, input logic signed [63:0] act,
                            input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic longint sat_ref(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    always @(negedge clk) begin
        if (!rst && ovalid && oready) begin
            check_eq("sb_has_entry", 64'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                longint e;
                e = exp_q.pop_front();
                $display("out %0d (expected %0d)", $signed(odata), e);
                check_eq("out_data", 64'($signed(odata)), e);
            end
        end
        if (done) done_cnt++;
    end

    task automatic do_start(input int len, input int np);
        start = 1'b1;
        plen  = 5'(len);
        npass = 8'(np);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_psum(input longint v);
        int n = 0;
        psum   = 16'(v);
        pvalid = 1'b1;
        @(negedge clk);
        while (!pready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("psum_accept_timeout", 64'(pready), 1);
        @(posedge clk); #1;
        pvalid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!done && n < 300);
        check_eq({tag, "_done"}, 64'(done), 1);
        check_eq({tag, "_drained"}, 64'(exp_q.size()), 0);
        check_eq({tag, "_busy_at_done"}, 64'(busy), 0);
        @(negedge clk); #1;
        check_eq({tag, "_done_width"}, 64'(done), 0);
    endtask

    task automatic run_job(input int len, input int np, input string tag);
        longint model [16];
        int k = 0;
        int base_done = done_cnt;
        do_start(len, np);
        for (int p = 0; p < np; p++) begin
            for (int i = 0; i < len; i++) begin
                longint v;
                v = stim[k];
                k++;
                model[i] = (p == 0) ? v : sat_ref(model[i] + v, ACC_W);
                if (p == np - 1) exp_q.push_back(model[i]);
                send_psum(v);
            end
        end
        wait_done(tag);
        check_eq({tag, "_done_count"}, 64'(done_cnt - base_done), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base_done;
        int n;
        start = 0; plen = 0; npass = 0; psum = 0; pvalid = 0; oready = 1;
        g_start = 0; g_plen = 0; g_npass = 0; g_psum = 0; g_pvalid = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_psum_ready", 64'(pready), 0);
        check_eq("rst_out_valid", 64'(ovalid), 0);
        check_eq("rst_out_data", 64'(odata), 0);
        check_eq("rst_busy", 64'(busy), 0);
        check_eq("rst_done", 64'(done), 0);
        check_eq("rst_overflow", 64'(ovf), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // T1: single pass, values pass straight through
        stim = '{5, -7, 100};
        run_job(3, 1, "t1");

        // T2: three passes accumulate; outputs only from the last pass
        stim = '{1, 2, 10, 20, 100, 200};
        run_job(2, 3, "t2");

        // Negative saturation on the default width: 17 x -32768 exceeds 20-bit range
        stim.delete();
        for (int i = 0; i < 17; i++) stim.push_back(-32768);
        run_job(1, 17, "negsat");
        check_eq("negsat_overflow", 64'(ovf), 1);

        // T6: empty job pulses done, stays idle, clears sticky overflow
        base_done = done_cnt;
        do_start(0, 1);
        check_eq("t6_len0_done", 64'(done), 1);
        check_eq("t6_len0_busy", 64'(busy), 0);
        check_eq("t6_ovf_cleared", 64'(ovf), 0);
        @(posedge clk); #1;
        check_eq("t6_len0_done_width", 64'(done), 0);
        do_start(3, 0);
        check_eq("t6_np0_done", 64'(done), 1);
        check_eq("t6_np0_busy", 64'(busy), 0);
        @(posedge clk); #1;
        check_eq("t6_len0_done_count", 64'(done_cnt - base_done), 2);

        // T6: start while busy is ignored
        base_done = done_cnt;
        do_start(2, 1);
        exp_q.push_back(7);
        send_psum(7);
        start = 1'b1; plen = 5'd1; npass = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("t6_busy_held", 64'(busy), 1);
        exp_q.push_back(-9);
        send_psum(-9);
        wait_done("t6b");
        check_eq("t6b_done_count", 64'(done_cnt - base_done), 1);

        // T4: backpressure from a full FIFO
        oready = 1'b0;
        stim = '{11, -22, 33, -44, 55, -66};
        do_start(6, 1);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(stim[i]);
            send_psum(stim[i]);
        end
        psum = 16'(55); pvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t4_ready_low_when_full", 64'(pready), 0);
        end
        check_eq("t4_out_valid_held", 64'(ovalid), 1);
        @(posedge clk); #1;
        oready = 1'b1;
        exp_q.push_back(55);
        send_psum(55);
        exp_q.push_back(-66);
        send_psum(-66);
        wait_done("t4");

        // T5: reset in pass 1 aborts, then T2 reruns cleanly
        base_done = done_cnt;
        do_start(2, 3);
        send_psum(1);
        send_psum(2);
        send_psum(10);
        rst = 1'b1;
        #2;
        check_eq("t5_rst_psum_ready", 64'(pready), 0);
        check_eq("t5_rst_out_valid", 64'(ovalid), 0);
        check_eq("t5_rst_out_data", 64'(odata), 0);
        check_eq("t5_rst_busy", 64'(busy), 0);
        check_eq("t5_rst_done", 64'(done), 0);
        check_eq("t5_rst_overflow", 64'(ovf), 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("t5_no_done_after_abort", 64'(done_cnt - base_done), 0);
        stim = '{1, 2, 10, 20, 100, 200};
        run_job(2, 3, "t5_rerun");

        // T3: GUARD=0 instance saturates 32767 + 1
        g_start = 1'b1; g_plen = 5'd1; g_npass = 8'd2;
        @(posedge clk); #1;
        g_start = 1'b0;
        g_psum = 16'h7fff; g_pvalid = 1'b1;
        @(negedge clk);
        check_eq("t3_ready_accum", 64'(g_pready), 1);
        @(posedge clk); #1;
        g_psum = 16'd1;
        @(negedge clk);
        check_eq("t3_ready_final", 64'(g_pready), 1);
        @(posedge clk); #1;
        g_pvalid = 1'b0;
        n = 0;
        while (!g_ovalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("t3_out_valid", 64'(g_ovalid), 1);
        $display("g0 out %0d (expected 32767)", $signed(g_odata));
        check_eq("t3_out_data", 64'($signed(g_odata)), 32767);
        check_eq("t3_overflow_set", 64'(g_ovf), 1);
        n = 0;
        while (g_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("t3_idle", 64'(g_busy), 0);
        @(posedge clk); #1;
        g_start = 1'b1; g_plen = 5'd0; g_npass = 8'd1;
        @(posedge clk); #1;
        g_start = 1'b0;
        check_eq("t3_overflow_cleared", 64'(g_ovf), 0);
        check_eq("t3_len0_done", 64'(g_done), 1);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
